// File: rtl/qspi_line_fetcher_pkg.sv
// Shared constants, phase boundaries and FSM encoding for the QSPI line fetcher.
// Phase boundaries are cycle counts measured from the first CMD cycle.
package qspi_line_fetcher_pkg;

    localparam int          QLF_NIBBLES      = 136;
    localparam int          QLF_DUMMY_CYCLES = 8;
    localparam logic [7:0]  QLF_SPI_CMD      = 8'h6B;

    localparam int QLF_CMD_END   = 8;
    localparam int QLF_ADDR_END  = 32;
    localparam int QLF_DUMMY_END = QLF_ADDR_END + QLF_DUMMY_CYCLES;
    localparam int QLF_DATA_END  = QLF_DUMMY_END + QLF_NIBBLES;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA
    } qlf_state_t;

endpackage

// File: rtl/qspi_line_fetcher_nibble_ram.sv
// Nibble line buffer: one write port, one registered read port, BANKS banks
// laid out back to back. Out-of-range reads return zero.
module qlf_nibble_ram
    import qspi_line_fetcher_pkg::*;
#(
    parameter int DEPTH = QLF_NIBBLES,
    parameter int BANKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_bank,
    input  logic [7:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       rd_bank,
    input  logic [7:0] rd_addr,
    output logic [3:0] rd_data
);

    localparam int AW = $clog2(DEPTH * BANKS);

    logic [3:0]    mem [DEPTH * BANKS];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          rd_valid;
    logic [3:0]    rd_data_reg;

    always_comb begin
        wr_idx   = AW'(32'(wr_bank) * DEPTH + 32'(wr_addr));
        rd_idx   = AW'(32'(rd_bank) * DEPTH + 32'(rd_addr));
        rd_valid = (32'(rd_addr) < DEPTH);
    end

    // Storage is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_reg <= 4'h0;
        end else if (rd_valid) begin
            rd_data_reg <= mem[rd_idx];
        end else begin
            rd_data_reg <= 4'h0;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/qspi_line_fetcher.sv
// Fetches one line of nibbles from a quad-output SPI flash into a local buffer.
// Define QLF_DOUBLE_BUFFER_EN for a ping-pong buffer swapped on each completed fetch.
module qspi_line_fetcher
    import qspi_line_fetcher_pkg::*;
#(
    parameter int         NIBBLES      = QLF_NIBBLES,
    parameter int         DUMMY_CYCLES = QLF_DUMMY_CYCLES,
    parameter logic [7:0] SPI_CMD      = QLF_SPI_CMD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] line_addr,
    output logic       busy,
    output logic       done,
    output logic       spi_cs,
    output logic       spi_sclk,
    input  logic [3:0] spi_in,
    output logic       spi_out0,
    output logic       spi_dir0,
    input  logic [7:0] rd_addr,
    output logic [3:0] rd_data
);

    localparam int DUMMY_END = QLF_ADDR_END + DUMMY_CYCLES;
    localparam int DATA_END  = DUMMY_END + NIBBLES;
`ifdef QLF_DOUBLE_BUFFER_EN
    localparam int BANKS = 2;
`else
    localparam int BANKS = 1;
`endif

    qlf_state_t  state_reg, state_next;
    logic [7:0]  cyc_reg, cyc_next;
    logic [6:0]  line_reg;
    logic        done_reg;
    logic        fetch_last;
    logic [23:0] addr24;
    logic [7:0]  wr_addr;
    logic        wr_bank;
    logic        rd_bank;

    assign fetch_last = (state_reg == DATA) && (cyc_reg == 8'(DATA_END - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cyc_reg   <= 8'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            done_reg  <= fetch_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            line_reg <= 7'd0;
        end else if (state_reg == IDLE && start) begin
            line_reg <= line_addr;
        end
    end

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg + 8'd1;
        case (state_reg)
            IDLE: begin
                cyc_next = 8'd0;
                if (start) state_next = CMD;
            end
            CMD:   if (cyc_reg == 8'(QLF_CMD_END - 1))  state_next = ADDR;
            ADDR:  if (cyc_reg == 8'(QLF_ADDR_END - 1)) state_next = DUMMY;
            DUMMY: if (cyc_reg == 8'(DUMMY_END - 1))    state_next = DATA;
            DATA: begin
                if (fetch_last) begin
                    state_next = IDLE;
                    cyc_next   = 8'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = 8'd0;
            end
        endcase
    end

    // Line index maps to flash ADDR[12:6]; address bits go out MSB first over cyc 8..31.
    assign addr24 = {11'd0, line_reg, 6'd0};

    always_comb begin
        spi_out0 = 1'b0;
        case (state_reg)
            CMD:     spi_out0 = SPI_CMD[~cyc_reg[2:0]];
            ADDR:    spi_out0 = addr24[~cyc_reg[4:0]];
            default: spi_out0 = 1'b0;
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign spi_cs   = (state_reg != IDLE);
    assign spi_dir0 = (state_reg == DUMMY) || (state_reg == DATA);
    assign spi_sclk = ~clk;
    assign done     = done_reg;
    assign wr_addr  = cyc_reg - 8'(DUMMY_END);

`ifdef QLF_DOUBLE_BUFFER_EN
    // Bank select returns to bank 0 on reset so the read bank is deterministic.
    logic bank_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bank_reg <= 1'b0;
        end else if (fetch_last) begin
            bank_reg <= ~bank_reg;
        end
    end

    assign wr_bank = bank_reg;
    assign rd_bank = ~bank_reg;
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

    qlf_nibble_ram #(
        .DEPTH (NIBBLES),
        .BANKS (BANKS)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (state_reg == DATA),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (spi_in),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_qspi_line_fetcher.sv
// Self-checking bench for qspi_line_fetcher: per-fetch SPI framing checks plus a
// read scoreboard fed from a reference nibble model.
module tb_qspi_line_fetcher;

    localparam int NIB = 136;

    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] line_addr;
    logic       busy;
    logic       done;
    logic       spi_cs;
    logic       spi_sclk;
    logic [3:0] spi_in;
    logic       spi_out0;
    logic       spi_dir0;
    logic [7:0] rd_addr;
    logic [3:0] rd_data;

    qspi_line_fetcher dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .line_addr (line_addr),
        .busy      (busy),
        .done      (done),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_in    (spi_in),
        .spi_out0  (spi_out0),
        .spi_dir0  (spi_dir0),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference buffer: two banks; only bank 0 is used in the single-bank build.
    logic [3:0] mdl [2][NIB];
    int         wbank = 0;

    function automatic logic [3:0] model_read(input int a);
        if (a >= NIB) return 4'h0;
`ifdef QLF_DOUBLE_BUFFER_EN
        return mdl[1 - wbank][a];
`else
        return mdl[0][a];
`endif
    endfunction

    task automatic model_write(input int i, input logic [3:0] d);
`ifdef QLF_DOUBLE_BUFFER_EN
        mdl[wbank][i] = d;
`else
        mdl[0][i] = d;
`endif
    endtask

    typedef struct {
        int         addr;
        logic [3:0] data;
    } rd_exp_t;

    rd_exp_t rd_q[$];

    // Called once per negedge: retire last cycle's read, then optionally issue one.
    task automatic rd_step(input bit issue, input int a);
        rd_exp_t e;
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check($sformatf("rd[%0d]", e.addr), 32'(rd_data), 32'(e.data));
        end
        if (issue) begin
            rd_addr = 8'(a);
            e.addr  = a;
            e.data  = model_read(a);
            rd_q.push_back(e);
        end
    endtask

    function automatic logic [3:0] pattern(input int pat, input int i);
        if (pat == 0) return 4'(i);
        return 4'(i * 7 + 3);
    endfunction

    // Entered and left on a negedge. rd_mode: 0 none, 1 location 0, 2 sweep.
    task automatic do_fetch(input logic [6:0] la, input int pat, input int abort_at,
                            input bit poke, input int rd_mode);
        int          cs_cnt = 0;
        int          busy_cnt = 0;
        int          stray = 0;
        int          dir_rise = -1;
        int          done_seen = 0;
        logic [31:0] mosi = 32'd0;
        logic [31:0] exp_mosi;
        logic [3:0]  nib;
        exp_mosi = {8'h6B, 11'd0, la, 6'd0};
        start     = 1'b1;
        line_addr = la;
        @(negedge clk);
        start     = 1'b0;
        line_addr = ~la;
        for (int k = 0; k < 176; k++) begin
            if (spi_cs) cs_cnt++;
            if (busy) busy_cnt++;
            if (done) done_seen++;
            if (k < 32) mosi = {mosi[30:0], spi_out0};
            else if (spi_out0) stray++;
            if (spi_dir0 && dir_rise < 0) dir_rise = k;
            rd_step(rd_mode != 0, (rd_mode == 1) ? 0 : (k % 140));
            start = poke && (k == 5 || k == 175);
            if (k >= 40) begin
                nib    = pattern(pat, k - 40);
                spi_in = nib;
                model_write(k - 40, nib);
            end
            if (k == 175) wbank = 1 - wbank;
            if (k == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                check("abort_cs", 32'(spi_cs), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_dir0", 32'(spi_dir0), 32'd0);
                check("abort_rd_data", 32'(rd_data), 32'd0);
                reset = 1'b1;
                for (int j = 0; j < 10; j++) begin
                    if (done) done_seen++;
                    @(negedge clk);
                end
                check("abort_cs_cycles", 32'(cs_cnt), 32'(abort_at + 1));
                check("abort_no_done", 32'(done_seen), 32'd0);
                $display("fetch line=%02h aborted at cyc=%0d", la, abort_at);
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("cs_after", 32'(spi_cs), 32'd0);
        rd_step(rd_mode != 0, (rd_mode == 1) ? 0 : 3);
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
        rd_step(1'b0, 0);
        check("cs_cycles", 32'(cs_cnt), 32'd176);
        check("busy_cycles", 32'(busy_cnt), 32'd176);
        check("mosi_bits", mosi, exp_mosi);
        check("mosi_stray", 32'(stray), 32'd0);
        check("dir0_rise", 32'(dir_rise), 32'd32);
        check("done_early", 32'(done_seen), 32'd0);
        $display("fetch line=%02h pattern=%0d complete", la, pat);
    endtask

    task automatic read_sweep();
        for (int a = 0; a < NIB; a++) begin
            rd_step(1'b1, a);
            @(negedge clk);
        end
        rd_step(1'b1, 200);
        @(negedge clk);
        rd_step(1'b0, 0);
        $display("read sweep 0..%0d and 200 complete", NIB - 1);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        line_addr = 7'd0;
        spi_in    = 4'h0;
        rd_addr   = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(spi_cs), 32'd0);
        check("rst_out0", 32'(spi_out0), 32'd0);
        check("rst_dir0", 32'(spi_dir0), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        do_fetch(7'h12, 1, 60, 1'b0, 0);
        do_fetch(7'h55, 0, -1, 1'b1, 0);
        read_sweep();
`ifdef QLF_DOUBLE_BUFFER_EN
        do_fetch(7'h2A, 1, -1, 1'b0, 2);
`else
        do_fetch(7'h2A, 1, -1, 1'b0, 1);
`endif
        read_sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
